// File: rtl/mtpsa_user_out_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mtpsa_user_out_arbiter
//  Purpose  : Packet-granular round-robin arbiter that merges NUM_USERS
//             per-tenant AXI4-Stream outputs into the single stream feeding
//             the output queues. A grant is held from the first beat of a
//             packet until its TLAST handshake, so tenants never interleave.
//             TUSER (digest + metadata) passes through untouched.
//  Options  : `define MTPSA_ARB_PKT_CNT_EN adds a per-user 32-bit count of
//             forwarded packets on output pkt_cnt.
//  Revision : 1.0 - initial release
// ============================================================================
module mtpsa_user_out_arbiter #(
    parameter int NUM_USERS          = 8,
    parameter int C_AXIS_DATA_WIDTH  = 256,
    parameter int C_AXIS_TUSER_WIDTH = 296,
    parameter int GRANT_WIDTH        = $clog2(NUM_USERS)
) (
    input  logic                                     axis_aclk,
    input  logic                                     axis_resetn,

    input  logic [NUM_USERS*C_AXIS_DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [NUM_USERS*C_AXIS_DATA_WIDTH/8-1:0] s_axis_tkeep,
    input  logic [NUM_USERS*C_AXIS_TUSER_WIDTH-1:0]  s_axis_tuser,
    input  logic [NUM_USERS-1:0]                     s_axis_tvalid,
    input  logic [NUM_USERS-1:0]                     s_axis_tlast,
    output logic [NUM_USERS-1:0]                     s_axis_tready,

    output logic [C_AXIS_DATA_WIDTH-1:0]             m_axis_tdata,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]           m_axis_tkeep,
    output logic [C_AXIS_TUSER_WIDTH-1:0]            m_axis_tuser,
    output logic                                     m_axis_tvalid,
    output logic                                     m_axis_tlast,
    input  logic                                     m_axis_tready,

    output logic [GRANT_WIDTH-1:0]                   grant_id,
    output logic                                     busy
`ifdef MTPSA_ARB_PKT_CNT_EN
    ,
    output logic [NUM_USERS*32-1:0]                  pkt_cnt
`endif
);

    localparam int c_KEEP_WIDTH = C_AXIS_DATA_WIDTH / 8;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_PASS = 1'b1
    } state_t;

    state_t                   r_state;
    state_t                   w_state_next;

    logic [GRANT_WIDTH-1:0]   r_grant_id;
    logic [GRANT_WIDTH-1:0]   r_last_grant;
    logic [GRANT_WIDTH-1:0]   w_next_grant;
    logic [GRANT_WIDTH-1:0]   w_idx;
    logic                     w_any_req;
    logic                     w_last_hs;

    // Per-user views of the flattened input buses
    logic [C_AXIS_DATA_WIDTH-1:0]  w_tdata [NUM_USERS];
    logic [c_KEEP_WIDTH-1:0]       w_tkeep [NUM_USERS];
    logic [C_AXIS_TUSER_WIDTH-1:0] w_tuser [NUM_USERS];

    genvar gi;

    // Slice the flattened inputs into one entry per user
    for (gi = 0; gi < NUM_USERS; gi++) begin : g_unpack
        assign w_tdata[gi] = s_axis_tdata[gi*C_AXIS_DATA_WIDTH  +: C_AXIS_DATA_WIDTH];
        assign w_tkeep[gi] = s_axis_tkeep[gi*c_KEEP_WIDTH       +: c_KEEP_WIDTH];
        assign w_tuser[gi] = s_axis_tuser[gi*C_AXIS_TUSER_WIDTH +: C_AXIS_TUSER_WIDTH];
    end

    // Round-robin search: first valid requester after the last grant, with wrap
    always_comb begin
        w_next_grant = r_last_grant;
        w_any_req    = 1'b0;
        w_idx        = '0;
        for (int k = 1; k <= NUM_USERS; k++) begin
            w_idx = GRANT_WIDTH'((int'(r_last_grant) + k) % NUM_USERS);
            if (!w_any_req && s_axis_tvalid[w_idx]) begin
                w_any_req    = 1'b1;
                w_next_grant = w_idx;
            end
        end
    end

    // Output mux: only the granted user reaches the master side, zero when idle
    always_comb begin
        m_axis_tdata  = '0;
        m_axis_tkeep  = '0;
        m_axis_tuser  = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        s_axis_tready = '0;
        if (r_state == ST_PASS) begin
            m_axis_tdata              = w_tdata[r_grant_id];
            m_axis_tkeep              = w_tkeep[r_grant_id];
            m_axis_tuser              = w_tuser[r_grant_id];
            m_axis_tvalid             = s_axis_tvalid[r_grant_id];
            m_axis_tlast              = s_axis_tlast[r_grant_id];
            s_axis_tready[r_grant_id] = m_axis_tready;
        end
    end

    // Final beat of the locked packet accepted downstream
    assign w_last_hs = (r_state == ST_PASS) & m_axis_tvalid & m_axis_tready & m_axis_tlast;

    // Next-state logic: lock on any request, release on the TLAST handshake
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_any_req) w_state_next = ST_PASS;
            ST_PASS: if (w_last_hs) w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Grant registers; last_grant resets to the top user so user 0 wins first
    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            r_grant_id   <= '0;
            r_last_grant <= GRANT_WIDTH'(NUM_USERS - 1);
        end else if (r_state == ST_IDLE && w_any_req) begin
            r_grant_id   <= w_next_grant;
            r_last_grant <= w_next_grant;
        end
    end

    assign grant_id = r_grant_id;
    assign busy     = (r_state == ST_PASS);

`ifdef MTPSA_ARB_PKT_CNT_EN
    // Per-user forwarded-packet counters, free-running with natural wrap
    for (gi = 0; gi < NUM_USERS; gi++) begin : g_pkt_cnt
        logic [31:0] r_cnt;

        // Count one packet per TLAST handshake of this user
        always_ff @(posedge axis_aclk or negedge axis_resetn) begin
            if (!axis_resetn) begin
                r_cnt <= '0;
            end else if (w_last_hs && (r_grant_id == GRANT_WIDTH'(gi))) begin
                r_cnt <= r_cnt + 32'd1;
            end
        end

        assign pkt_cnt[gi*32 +: 32] = r_cnt;
    end
`endif

endmodule
`default_nettype wire
